// File: rtl/vram_console_writer.sv
// Console text writer for a linear character VRAM: places printable bytes at the cursor,
// handles CR/LF/BS/FF, and scrolls the screen up one row when the cursor runs off the bottom.
module vram_console_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        vclk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] addr,
    output logic [7:0]  din,
    output logic        we,
    input  logic [7:0]  dout,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a byte; only state that accepts input
    // PUT    | single-cycle character write at the cursor
    // SCR_RD | scroll: read source cell one row below destination
    // SCR_WR | scroll: write the read data one row up
    // CLR    | fill with spaces (whole screen, or last row after a scroll)
    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
    localparam logic [12:0] SRC_START     = 13'(COLS);
    localparam logic [12:0] SRC_END       = 13'(COLS * ROWS);
    localparam logic [11:0] LAST_ADDR     = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);
    localparam logic [7:0]  SPACE         = 8'h20;

    state_t      state_q;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic [11:0] addr_q;
    logic [7:0]  din_q;
    logic        we_q;
    logic        no_adv_q;
    logic        full_clr_q;
    logic [12:0] src_q;

    logic [11:0] cur_addr_d;
    logic [12:0] src_d;
    logic [11:0] dst_d;

    assign cur_addr_d = 12'(row_q) * 12'(COLS) + 12'(col_q);
    assign src_d      = src_q + 13'd1;
    assign dst_d      = 12'(src_q - SRC_START);

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign addr     = addr_q;
    assign we       = we_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;
    // Synchronous RAM read lands during SCR_WR, so scroll data bypasses the din register.
    assign din      = (state_q == SCR_WR) ? dout : din_q;

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            no_adv_q   <= 1'b0;
            full_clr_q <= 1'b0;
            src_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_data >= 8'h20 && in_data != 8'h7F) begin
                            state_q  <= PUT;
                            we_q     <= 1'b1;
                            addr_q   <= cur_addr_d;
                            din_q    <= in_data;
                            no_adv_q <= 1'b0;
                        end else begin
                            case (in_data)
                                8'h0D: col_q <= '0;
                                8'h0A: begin
                                    col_q <= '0;
                                    if (row_q == LAST_ROW) begin
                                        state_q <= SCR_RD;
                                        src_q   <= SRC_START;
                                        addr_q  <= 12'(COLS);
                                    end else begin
                                        row_q <= row_q + 5'd1;
                                    end
                                end
                                8'h08: begin
                                    if (col_q != 7'd0) begin
                                        col_q    <= col_q - 7'd1;
                                        state_q  <= PUT;
                                        we_q     <= 1'b1;
                                        addr_q   <= cur_addr_d - 12'd1;
                                        din_q    <= SPACE;
                                        no_adv_q <= 1'b1;
                                    end
                                end
                                8'h0C: begin
                                    state_q    <= CLR;
                                    we_q       <= 1'b1;
                                    addr_q     <= '0;
                                    din_q      <= SPACE;
                                    full_clr_q <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PUT: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                    if (!no_adv_q) begin
                        if (col_q != LAST_COL) begin
                            col_q <= col_q + 7'd1;
                        end else begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                state_q <= SCR_RD;
                                src_q   <= SRC_START;
                                addr_q  <= 12'(COLS);
                            end else begin
                                row_q <= row_q + 5'd1;
                            end
                        end
                    end
                end
                SCR_RD: begin
                    state_q <= SCR_WR;
                    addr_q  <= dst_d;
                    we_q    <= 1'b1;
                end
                SCR_WR: begin
                    src_q <= src_d;
                    if (src_d == SRC_END) begin
                        state_q    <= CLR;
                        addr_q     <= LAST_ROW_BASE;
                        din_q      <= SPACE;
                        we_q       <= 1'b1;
                        full_clr_q <= 1'b0;
                    end else begin
                        state_q <= SCR_RD;
                        addr_q  <= src_d[11:0];
                        we_q    <= 1'b0;
                    end
                end
                CLR: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                        if (full_clr_q) begin
                            col_q <= '0;
                            row_q <= '0;
                        end
                    end else begin
                        addr_q <= addr_q + 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_console_writer.sv
// Directed bench for vram_console_writer with a synchronous-read VRAM model.
module tb_vram_console_writer;

    logic        vclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] addr;
    logic [7:0]  din;
    logic        we;
    logic [7:0]  dout;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:4095];
    logic       load_req = 1'b0;
    int         wcount = 0;
    logic       trk_en = 1'b0;
    int         trk_next = 0;
    int         trk_bad = 0;

    vram_console_writer #(.COLS(80), .ROWS(30)) dut (
        .vclk(vclk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .addr(addr), .din(din), .we(we), .dout(dout),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 vclk = ~vclk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    always @(posedge vclk) begin
        if (load_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (we === 1'b1) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
        if (we === 1'b1) wcount <= wcount + 1;
        if (!trk_en) begin
            trk_next <= 0;
        end else if (we === 1'b1) begin
            if (32'(addr) != trk_next || din != 8'h20) trk_bad <= trk_bad + 1;
            trk_next <= trk_next + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge vclk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20000) begin
            @(negedge vclk);
            n++;
        end
        if (n >= 20000) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge vclk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int w0;
        int bad;

        repeat (3) @(negedge vclk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        send(8'h41);
        chk("A_we", 32'(we), 32'd1);
        chk("A_addr", 32'(addr), 32'd0);
        chk("A_din", 32'(din), 32'h41);
        chk("A_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("A_we_off", 32'(we), 32'd0);
        chk("A_ready_back", 32'(in_ready), 32'd1);
        chk("A_col", 32'(cur_col), 32'd1);
        chk("A_mem", 32'(mem[0]), 32'h41);

        w0 = wcount;
        send(8'h0D);
        chk("CR_ready", 32'(in_ready), 32'd1);
        chk("CR_col", 32'(cur_col), 32'd0);
        send(8'h01);
        send(8'h7F);
        tick();
        chk("CTL_nowrite", 32'(wcount - w0), 32'd0);
        chk("CTL_col", 32'(cur_col), 32'd0);
        chk("CTL_row", 32'(cur_row), 32'd0);

        for (int i = 0; i < 5; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'(8'h61 + (i % 26)));
        tick();
        chk("pre_wrap_col", 32'(cur_col), 32'd79);
        chk("pre_wrap_row", 32'(cur_row), 32'd5);
        send(8'h42);
        chk("wrap_addr", 32'(addr), 32'd479);
        chk("wrap_din", 32'(din), 32'h42);
        chk("wrap_we", 32'(we), 32'd1);
        tick();
        chk("wrap_col", 32'(cur_col), 32'd0);
        chk("wrap_row", 32'(cur_row), 32'd6);
        chk("wrap_mem", 32'(mem[479]), 32'h42);

        @(negedge vclk);
        trk_en = 1'b1;
        w0 = wcount;
        send(8'h0C);
        wait_idle(n);
        trk_en = 1'b0;
        chk("FF_busy_cycles", 32'(n), 32'd2400);
        chk("FF_writes", 32'(wcount - w0), 32'd2400);
        chk("FF_seq_bad", 32'(trk_bad), 32'd0);
        chk("FF_col", 32'(cur_col), 32'd0);
        chk("FF_row", 32'(cur_row), 32'd0);

        send(8'h0A);
        send(8'h0A);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        tick();
        chk("BS_pre_col", 32'(cur_col), 32'd3);
        send(8'h08);
        chk("BS_col_now", 32'(cur_col), 32'd2);
        chk("BS_addr", 32'(addr), 32'd162);
        chk("BS_din", 32'(din), 32'h20);
        chk("BS_we", 32'(we), 32'd1);
        tick();
        chk("BS_col", 32'(cur_col), 32'd2);
        chk("BS_row", 32'(cur_row), 32'd2);
        chk("BS_mem", 32'(mem[162]), 32'h20);
        send(8'h08);
        send(8'h08);
        tick();
        w0 = wcount;
        send(8'h08);
        tick();
        chk("BS0_nowrite", 32'(wcount - w0), 32'd0);
        chk("BS0_col", 32'(cur_col), 32'd0);
        chk("BS0_row", 32'(cur_row), 32'd2);
        chk("BS0_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 27; i++) send(8'h0A);
        chk("SCR_pre_row", 32'(cur_row), 32'd29);
        @(negedge vclk);
        load_req = 1'b1;
        @(posedge vclk);
        #1;
        load_req = 1'b0;
        send(8'h0A);
        wait_idle(n);
        chk("SCR_busy_cycles", 32'(n), 32'd4720);
        bad = 0;
        for (int r = 0; r < 29; r++)
            for (int c = 0; c < 80; c++)
                if (mem[r * 80 + c] !== pat((r + 1) * 80 + c)) bad++;
        chk("SCR_moved_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int a = 2320; a < 2400; a++) if (mem[a] !== 8'h20) bad++;
        chk("SCR_lastrow_bad", 32'(bad), 32'd0);
        chk("SCR_col", 32'(cur_col), 32'd0);
        chk("SCR_row", 32'(cur_row), 32'd29);

        send(8'h0A);
        repeat (100) tick();
        n = 0;
        while (we !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("RST_mid_we_seen", 32'(we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("RST_we", 32'(we), 32'd0);
        chk("RST_col", 32'(cur_col), 32'd0);
        chk("RST_row", 32'(cur_row), 32'd0);
        chk("RST_ready", 32'(in_ready), 32'd1);
        chk("RST_busy", 32'(busy), 32'd0);
        chk("RST_addr", 32'(addr), 32'd0);
        @(negedge vclk);
        rst_n = 1'b1;
        send(8'h5A);
        chk("RST_next_addr", 32'(addr), 32'd0);
        chk("RST_next_din", 32'(din), 32'h5A);
        chk("RST_next_we", 32'(we), 32'd1);
        tick();
        chk("RST_next_col", 32'(cur_col), 32'd1);
        chk("RST_next_mem", 32'(mem[0]), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
